// File: rtl/sys_ctrl_pkg.sv
// sys_ctrl_pkg: shared states and constants for the register-file command controller
package sys_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND} state_t;
  localparam logic [7:0] CMD_WR_DEF = 8'hAA;
  localparam logic [7:0] CMD_RD_DEF = 8'hBB;
  localparam int TX_W = 8;
endpackage

// File: rtl/ctrl_timeout.sv
// ctrl_timeout: loadable down-counter that flags expiry after LOAD enabled cycles
module ctrl_timeout #(
  parameter int LOAD = 4,
  localparam int W = $clog2(LOAD + 1)
) (
  input  logic CLK,
  input  logic RST,
  input  logic restart,
  input  logic en,
  output logic expired
);
  logic [W-1:0] cnt;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) cnt <= '0;
    else if (restart) cnt <= W'(LOAD);
    else if (en && cnt != '0) cnt <= cnt - W'(1);
  assign expired = cnt == '0;
endmodule

// File: rtl/sys_ctrl.sv
// sys_ctrl: parses UART command frames into register-file accesses and returns read data
module sys_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int ADDR = $clog2(DEPTH),
  parameter int WIDTH = 8,
  parameter logic [7:0] CMD_WR = CMD_WR_DEF,
  parameter logic [7:0] CMD_RD = CMD_RD_DEF,
  parameter int FRAME_TO = 255,
  parameter int RD_TO = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [7:0]       RX_P_DATA,
  input  logic             RX_D_VLD,
  input  logic [WIDTH-1:0] RdData,
  input  logic             RdData_VLD,
  output logic             WrEn,
  output logic             RdEn,
  output logic [ADDR-1:0]  Address,
  output logic [WIDTH-1:0] WrData,
  output logic [TX_W-1:0]  TX_P_DATA,
  output logic             TX_D_VLD,
  input  logic             TX_BUSY,
  output logic             CMD_ERR
);
  state_t state, state_d;
  logic [ADDR-1:0] addr_q, addr_d, address_d;
  logic [WIDTH-1:0] wr_data_d;
  logic [TX_W-1:0] tx_data_d;
  logic wr_en_d, rd_en_d, tx_vld_d, err_d, in_frame, frame_exp, rd_exp, bad_addr;
  assign in_frame = state inside {WR_ADDR, WR_DATA, RD_ADDR};
  assign bad_addr = 32'(RX_P_DATA) >= 32'(DEPTH);
  ctrl_timeout #(.LOAD(FRAME_TO - 1)) u_frame_to (
    .CLK(CLK), .RST(RST), .restart(RX_D_VLD || !in_frame), .en(in_frame), .expired(frame_exp)
  );
  ctrl_timeout #(.LOAD(RD_TO)) u_rd_to (
    .CLK(CLK), .RST(RST), .restart(state != RD_WAIT), .en(state == RD_WAIT), .expired(rd_exp)
  );
  always_comb begin
    state_d = state;
    addr_d = addr_q;
    address_d = Address;
    wr_data_d = WrData;
    tx_data_d = TX_P_DATA;
    wr_en_d = 1'b0;
    rd_en_d = 1'b0;
    tx_vld_d = 1'b0;
    err_d = 1'b0;
    case (state)
      IDLE: if (RX_D_VLD) begin
        state_d = RX_P_DATA == CMD_WR ? WR_ADDR : RX_P_DATA == CMD_RD ? RD_ADDR : IDLE;
        err_d = RX_P_DATA != CMD_WR && RX_P_DATA != CMD_RD;
      end
      WR_ADDR, RD_ADDR: if (RX_D_VLD) begin
        err_d = bad_addr;
        addr_d = bad_addr ? addr_q : RX_P_DATA[ADDR-1:0];
        rd_en_d = !bad_addr && state == RD_ADDR;
        address_d = rd_en_d ? RX_P_DATA[ADDR-1:0] : Address;
        state_d = bad_addr ? IDLE : state == WR_ADDR ? WR_DATA : RD_WAIT;
      end else if (frame_exp) begin
        err_d = 1'b1;
        state_d = IDLE;
      end
      WR_DATA: if (RX_D_VLD) begin
        wr_en_d = 1'b1;
        address_d = addr_q;
        wr_data_d = RX_P_DATA;
        state_d = IDLE;
      end else if (frame_exp) begin
        err_d = 1'b1;
        state_d = IDLE;
      end
      RD_WAIT: begin
        err_d = RX_D_VLD || (!RdData_VLD && rd_exp);
        tx_vld_d = RdData_VLD && !TX_BUSY;
        tx_data_d = RdData_VLD ? RdData : TX_P_DATA;
        state_d = RdData_VLD ? (TX_BUSY ? TX_SEND : IDLE) : rd_exp ? IDLE : RD_WAIT;
      end
      TX_SEND: begin
        err_d = RX_D_VLD;
        tx_vld_d = !TX_BUSY;
        state_d = TX_BUSY ? TX_SEND : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state <= IDLE;
      addr_q <= '0;
      Address <= '0;
      WrData <= '0;
      TX_P_DATA <= '0;
      WrEn <= 1'b0;
      RdEn <= 1'b0;
      TX_D_VLD <= 1'b0;
      CMD_ERR <= 1'b0;
    end else begin
      state <= state_d;
      addr_q <= addr_d;
      Address <= address_d;
      WrData <= wr_data_d;
      TX_P_DATA <= tx_data_d;
      WrEn <= wr_en_d;
      RdEn <= rd_en_d;
      TX_D_VLD <= tx_vld_d;
      CMD_ERR <= err_d;
    end
endmodule

// File: doc/sys_ctrl.md
Name: sys_ctrl

Overview:
Byte-command controller that sequences the register file from a serial receive path. It parses write frames (CMD_WR, addr, data) and read frames (CMD_RD, addr) and drives the register file's WrEn/RdEn/Address/WrData. Read results go out through a byte-wide transmit handshake with busy backpressure. It sits between the UART RX/TX byte interfaces and the register file in the system top.

Parameters:
DEPTH, 16, number of register-file entries
ADDR, $clog2(DEPTH), address width
WIDTH, 8, data width; must equal 8 (byte framing)
CMD_WR, 8'hAA, write-frame opcode
CMD_RD, 8'hBB, read-frame opcode
FRAME_TO, 255, max idle cycles between bytes of one frame
RD_TO, 4, max cycles from RdEn to RdData_VLD

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous active-low reset
RX_P_DATA  in  8  received byte
RX_D_VLD  in  1  one-cycle strobe, RX_P_DATA valid
RdData  in  WIDTH  register-file read data
RdData_VLD  in  1  register-file read-data valid
WrEn  out  1  register-file write enable
RdEn  out  1  register-file read enable
Address  out  ADDR  register-file address
WrData  out  WIDTH  register-file write data
TX_P_DATA  out  8  byte to transmit
TX_D_VLD  out  1  one-cycle strobe, TX_P_DATA valid
TX_BUSY  in  1  transmitter busy; no TX_D_VLD while high
CMD_ERR  out  1  one-cycle error pulse

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, latched addr/data 0. All outputs are registered.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND.
- IDLE, on RX_D_VLD:
  - CMD_WR -> WR_ADDR.
  - CMD_RD -> RD_ADDR.
  - Any other byte -> CMD_ERR pulse; stay in IDLE.
- WR_ADDR / RD_ADDR, on RX_D_VLD:
  - If byte >= DEPTH -> CMD_ERR, go to IDLE.
  - Else latch RX_P_DATA[ADDR-1:0]. WR_ADDR -> WR_DATA.
  - RD_ADDR -> RD_WAIT, with RdEn=1 and Address driven in the next cycle, for exactly 1 cycle.
- WR_DATA, on RX_D_VLD: next cycle WrEn=1, Address=latched, WrData=byte for exactly 1 cycle; then IDLE.
- Address holds its last value when WrEn and RdEn are both 0.
- Frame timer: in WR_ADDR, WR_DATA and RD_ADDR, a counter restarts on entry and on each RX_D_VLD. At FRAME_TO cycles without a byte -> CMD_ERR, go to IDLE.
- RD_WAIT:
  - On RdData_VLD, latch RdData into the TX buffer -> TX_SEND. Nominal RdData_VLD arrives the cycle after RdEn.
  - If there is no RdData_VLD within RD_TO cycles of RdEn -> CMD_ERR, go to IDLE.
- TX_SEND: in the first cycle with TX_BUSY=0, assert TX_D_VLD=1 with TX_P_DATA=buffer for 1 cycle; then IDLE. Otherwise wait indefinitely.
- Read latency, TX_BUSY=0: address byte strobe at cycle N -> RdEn at N+1 -> RdData_VLD at N+2 -> TX_D_VLD at N+3.
- WrEn and RdEn are never high in the same cycle (the register file ignores both).
- RX_D_VLD received in RD_WAIT or TX_SEND: byte dropped, CMD_ERR pulses, state unaffected.
- Simultaneous error sources in one cycle produce a single CMD_ERR pulse.
- Reset mid-frame or mid-read: immediate return to IDLE. No WrEn/RdEn/TX_D_VLD is issued for the aborted frame.

Decomposition:
- Package sys_ctrl_pkg holds:
  - the state enum (6 states);
  - default CMD_WR/CMD_RD codes;
  - a 1-cycle strobe helper constant for width of TX byte (8).
- One natural sub-module: ctrl_timeout, a loadable down-counter with restart/enable/expired. It is instantiated twice: frame timer and read timer.

Test Plan:
- Write frame AA,05,3C with 2 idle cycles between bytes -> single WrEn pulse with Address=5, WrData=8'h3C; CMD_ERR stays 0.
- Read frame BB,02, register file returning 8'h81, TX_BUSY=0 -> RdEn at N+1, TX_D_VLD with TX_P_DATA=8'h81 at N+3.
- Same read with TX_BUSY held high for 10 cycles -> TX_D_VLD occurs exactly 1 cycle after TX_BUSY falls; an extra RX byte during the wait gives CMD_ERR and no state change.
- Error cases, each -> one CMD_ERR pulse, return to IDLE, no WrEn/RdEn:
  - opcode 8'h12;
  - address byte 8'h10 with DEPTH=16;
  - AA,05 then FRAME_TO idle cycles.
- RdData_VLD withheld after RdEn -> CMD_ERR at RD_TO cycles; the next frame AA,01,FF is processed normally.
- RST low during WR_DATA -> all outputs 0; a subsequent data byte produces no WrEn.
